// File: rtl/mips32_boot_loader.sv
// Boot loader: framed byte stream -> big-endian words in instruction memory.
// Core is held in reset until a full image with a matching XOR checksum lands.
module mips32_boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [8:0]  word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t      state, state_d;
  logic [7:0]  chk;
  logic [1:0]  idx;
  logic [23:0] shreg;
  logic [8:0]  remain;
  logic [31:0] idle_cnt;
  logic        take, word_end, last_byte, tmo_on, tmo_hit;

  assign in_ready  = state inside {S_IDLE, S_COUNT, S_DATA, S_CHECK};
  assign take      = in_valid && in_ready && !restart;
  assign word_end  = take && (state == S_DATA) && (idx == 2'd3);
  assign last_byte = word_end && (remain == 9'd1);
  assign tmo_on    = (TIMEOUT_CYCLES != 0) &&
                     (state inside {S_COUNT, S_DATA, S_CHECK});
  assign tmo_hit   = tmo_on && !take &&
                     ((idle_cnt + 32'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (restart) begin
      state_d = S_IDLE;
    end else if (tmo_hit) begin
      state_d = S_ERROR;
    end else if (take) begin
      unique case (state)
        S_IDLE:  if (in_data == SYNC_BYTE) state_d = S_COUNT;
        S_COUNT: state_d = S_DATA;
        S_DATA:  if (last_byte) state_d = S_CHECK;
        S_CHECK: state_d = (in_data == chk) ? S_DONE : S_ERROR;
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'h0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      word_count <= 9'd0;
      chk        <= 8'h00;
      idx        <= 2'd0;
      shreg      <= 24'h0;
      remain     <= 9'd0;
      idle_cnt   <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      // the write strobed last cycle retires here, even across restart
      if (imem_we) begin
        imem_addr  <= imem_addr + 32'd4;
        word_count <= word_count + 9'd1;
      end
      if (restart) begin
        cpu_reset  <= 1'b1;
        load_done  <= 1'b0;
        load_error <= 1'b0;
        word_count <= 9'd0;
        chk        <= 8'h00;
        idx        <= 2'd0;
        idle_cnt   <= 32'd0;
      end else begin
        if (!tmo_on || take) idle_cnt <= 32'd0;
        else                 idle_cnt <= idle_cnt + 32'd1;
        if (state_d == S_DONE && state != S_DONE) begin
          load_done <= 1'b1;
          cpu_reset <= 1'b0;
        end
        if (state_d == S_ERROR) load_error <= 1'b1;
        if (take && state == S_COUNT) begin
          remain     <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          chk        <= 8'h00;
          idx        <= 2'd0;
          word_count <= 9'd0;
          imem_addr  <= BASE_ADDR;
        end
        if (take && state == S_DATA) begin
          chk   <= chk ^ in_data;
          idx   <= idx + 2'd1;
          shreg <= {shreg[15:0], in_data};
          if (word_end) begin
            imem_we    <= 1'b1;
            imem_wdata <= {shreg, in_data};
            remain     <= remain - 9'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Bench for mips32_boot_loader: directed frames plus random frames/gaps
// checked against a frame-level model of writes, checksum and timeout.
module tb_mips32_boot_loader;

  localparam int unsigned TMO  = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_reset, load_done, load_error;
  logic [31:0] imem_addr, imem_wdata;
  logic [8:0]  word_count;
  logic        ready0, we0, cpures0, done0, err0;
  logic [31:0] addr0, wdata0;
  logic [8:0]  wc0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] wrq[$];
  logic [7:0]  fr_bytes[$];
  int          fr_gaps[$];
  bit          use0 = 1'b0;

  always #5 clk = ~clk;

  mips32_boot_loader #(
    .BASE_ADDR(BASE), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done),
    .load_error(load_error), .word_count(word_count)
  );

  mips32_boot_loader #(
    .BASE_ADDR(BASE), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(0)
  ) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready0), .restart(restart), .imem_we(we0),
    .imem_addr(addr0), .imem_wdata(wdata0),
    .cpu_reset(cpures0), .load_done(done0),
    .load_error(err0), .word_count(wc0)
  );

  always @(negedge clk) if (imem_we) wrq.push_back({imem_addr, imem_wdata});

  task automatic expect_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    rdy = use0 ? ready0 : in_ready;
    if (rdy) begin
      in_valid = 1'b1;
      in_data  = b;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    in_valid = 1'b0;
    restart  = 1'b1;
    @(negedge clk);
    restart  = 1'b0;
  endtask

  task automatic new_frame(input int n);
    fr_bytes.delete();
    fr_gaps.delete();
    fr_bytes.push_back(8'hA5);
    fr_bytes.push_back(8'(n));
  endtask

  task automatic seal(input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 2; k < fr_bytes.size(); k++) x ^= fr_bytes[k];
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    fr_bytes.push_back(x);
    while (fr_gaps.size() < fr_bytes.size()) fr_gaps.push_back(0);
  endtask

  task automatic play_and_check(input string tag);
    int n, cut, ndat, nw;
    bit tmo, good;
    logic [7:0]  x;
    logic [31:0] w;
    n   = (fr_bytes[1] == 8'h00) ? 256 : int'(fr_bytes[1]);
    cut = fr_bytes.size();
    tmo = 1'b0;
    for (int j = 1; j < fr_bytes.size(); j++)
      if (!tmo && fr_gaps[j] >= int'(TMO)) begin
        cut = j;
        tmo = 1'b1;
      end
    ndat = cut - 2;
    if (ndat < 0) ndat = 0;
    if (ndat > 4 * n) ndat = 4 * n;
    nw = ndat / 4;
    x = 8'h00;
    for (int k = 0; k < 4 * n; k++) x ^= fr_bytes[2 + k];
    good = !tmo && (fr_bytes[2 + 4 * n] == x);
    wrq.delete();
    for (int j = 0; j < fr_bytes.size(); j++) send_byte(fr_bytes[j], fr_gaps[j]);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    expect_eq({tag, " writes"}, 64'(wrq.size()), 64'(nw));
    for (int k = 0; k < nw && k < wrq.size(); k++) begin
      w = {fr_bytes[2 + 4 * k], fr_bytes[3 + 4 * k],
           fr_bytes[4 + 4 * k], fr_bytes[5 + 4 * k]};
      expect_eq($sformatf("%s wr%0d", tag, k), wrq[k], {BASE + 32'(4 * k), w});
    end
    expect_eq({tag, " word_count"}, 64'(word_count), 64'(nw));
    expect_eq({tag, " load_done"}, 64'(load_done), 64'(good));
    expect_eq({tag, " load_error"}, 64'(load_error), 64'(!good));
    expect_eq({tag, " cpu_reset"}, 64'(cpu_reset), 64'(!good));
    expect_eq({tag, " in_ready"}, 64'(in_ready), 64'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    expect_eq({tag, " in_ready"}, 64'(in_ready), 64'(1));
    expect_eq({tag, " imem_we"}, 64'(imem_we), 64'(0));
    expect_eq({tag, " imem_addr"}, 64'(imem_addr), 64'(BASE));
    expect_eq({tag, " imem_wdata"}, 64'(imem_wdata), 64'(0));
    expect_eq({tag, " cpu_reset"}, 64'(cpu_reset), 64'(1));
    expect_eq({tag, " load_done"}, 64'(load_done), 64'(0));
    expect_eq({tag, " load_error"}, 64'(load_error), 64'(0));
    expect_eq({tag, " word_count"}, 64'(word_count), 64'(0));
  endtask

  task automatic frame_two(input bit bad);
    new_frame(2);
    fr_bytes.push_back(8'h20); fr_bytes.push_back(8'h08);
    fr_bytes.push_back(8'h00); fr_bytes.push_back(8'h05);
    fr_bytes.push_back(8'h8C); fr_bytes.push_back(8'h09);
    fr_bytes.push_back(8'h00); fr_bytes.push_back(8'h04);
    if (bad) begin
      fr_bytes.push_back(8'h00);
      while (fr_gaps.size() < fr_bytes.size()) fr_gaps.push_back(0);
    end else begin
      seal(1'b0);
    end
  endtask

  task automatic frame_one(input int gap);
    new_frame(1);
    fr_bytes.push_back(8'hDE); fr_bytes.push_back(8'hAD);
    fr_bytes.push_back(8'hBE); fr_bytes.push_back(8'hEF);
    seal(1'b0);
    fr_gaps[2] = gap;
  endtask

  initial begin
    reset    = 1'b0;
    restart  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    frame_two(1'b0);
    play_and_check("good2");
    pulse_restart();
    expect_eq("rs cpu_reset", 64'(cpu_reset), 64'(1));
    expect_eq("rs load_done", 64'(load_done), 64'(0));
    expect_eq("rs word_count", 64'(word_count), 64'(0));
    expect_eq("rs in_ready", 64'(in_ready), 64'(1));
    frame_one(0);
    play_and_check("after_rs");

    pulse_restart();
    frame_two(1'b1);
    play_and_check("badchk");

    pulse_restart();
    wrq.delete();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h13, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    expect_eq("junk writes", 64'(wrq.size()), 64'(0));
    expect_eq("junk in_ready", 64'(in_ready), 64'(1));
    frame_two(1'b0);
    play_and_check("junk_then_good");

    pulse_restart();
    frame_one(int'(TMO) - 1);
    play_and_check("gap1023");
    pulse_restart();
    frame_one(int'(TMO));
    play_and_check("gap1024");

    pulse_restart();
    frame_one(int'(TMO));
    use0 = 1'b1;
    for (int j = 0; j < fr_bytes.size(); j++) send_byte(fr_bytes[j], fr_gaps[j]);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    use0 = 1'b0;
    expect_eq("t0 load_done", 64'(done0), 64'(1));
    expect_eq("t0 word_count", 64'(wc0), 64'(1));
    expect_eq("t0 wdata", 64'(wdata0), 64'(32'hDEADBEEF));
    expect_eq("t0 cpu_reset", 64'(cpures0), 64'(0));
    expect_eq("t1024 load_error", 64'(load_error), 64'(1));

    for (int f = 0; f < 16; f++) begin
      int n;
      n = $urandom_range(1, 6);
      pulse_restart();
      new_frame(n);
      repeat (4 * n) fr_bytes.push_back(8'($urandom));
      seal($urandom_range(0, 3) == 0);
      for (int j = 0; j < fr_gaps.size(); j++) fr_gaps[j] = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0)
        fr_gaps[$urandom_range(1, fr_bytes.size() - 1)] = $urandom_range(1020, 1028);
      play_and_check($sformatf("rnd%0d", f));
    end

    pulse_restart();
    new_frame(0);
    repeat (1024) fr_bytes.push_back(8'($urandom));
    seal(1'b0);
    play_and_check("n256");
    expect_eq("n256 last addr", 64'(wrq[$][63:32]), 64'(BASE + 32'h3FC));

    pulse_restart();
    new_frame(2);
    repeat (4) fr_bytes.push_back(8'($urandom));
    for (int j = 0; j < fr_bytes.size(); j++) send_byte(fr_bytes[j], 0);
    @(negedge clk);
    in_valid = 1'b0;
    expect_eq("mid imem_we pending", 64'(imem_we), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    wrq.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
